debug_ctrl: RTL and testbench

Debug/halt controller sitting directly downstream of the APB status register. It consumes the level-mode DEBUG_REQUEST and the short-pulse RESET_REQUEST, drives the CPU core's stall and reset inputs, and returns DEBUG_ACK and HALTED to the status register for readback. It converts the register-level requests into a safe, instruction-boundary-aligned halt/resume protocol and a stretched core reset.

---
 rtl/debug_ctrl_pkg.sv | 14 +
 rtl/debug_ctrl_reset_stretch.sv | 46 ++++
 rtl/debug_ctrl.sv | 112 +++++++++++
 tb/tb_debug_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/debug_ctrl_pkg.sv
// Shared types and constants for the debug/halt controller.
package debug_ctrl_pkg;

  localparam int RESET_HOLD_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_RESETTING = 3'd0,
    S_RUN       = 3'd1,
    S_HALTING   = 3'd2,
    S_HALTED    = 3'd3,
    S_STEPPING  = 3'd4
  } dbg_state_e;

endpackage

// File: rtl/debug_ctrl_reset_stretch.sv
// Core reset stretcher: holds the core in reset until RESET_HOLD quiet cycles
// have followed the last sampled RESET_REQUEST, and flags completion to the FSM.
module reset_stretch #(
  parameter int RESET_HOLD = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic done_o,
  output logic core_rst_no
);

  localparam int CW = $clog2(RESET_HOLD + 1);
  localparam logic [CW-1:0] HOLD_VAL = CW'(RESET_HOLD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rstn_q, rstn_d;

  // Release coincides with the FSM leaving RESETTING: counter empty, no request.
  always_comb begin
    cnt_d  = cnt_q;
    rstn_d = rstn_q;
    if (req_i) begin
      cnt_d  = HOLD_VAL;
      rstn_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      rstn_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= HOLD_VAL;
      rstn_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rstn_q <= rstn_d;
    end
  end

  assign done_o      = (cnt_q == '0);
  assign core_rst_no = rstn_q;

endmodule

// File: rtl/debug_ctrl.sv
// Debug/halt controller: instruction-boundary halt/resume plus stretched core reset.
// Single-step support (STEPPING state, STEP_REQUEST/CPU_RETIRE) built only with SINGLE_STEP_EN.
module debug_ctrl
  import debug_ctrl_pkg::*;
#(
  parameter int RESET_HOLD = RESET_HOLD_DEFAULT
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic DEBUG_REQUEST,
  input  logic RESET_REQUEST,
  input  logic STEP_REQUEST,
  output logic DEBUG_ACK,
  output logic HALTED,
  output logic CPU_HALT,
  input  logic CPU_IDLE,
  input  logic CPU_RETIRE,
  output logic CPU_RESETn
);

  dbg_state_e state_q, state_d;
  logic       pend_q, pend_d;
  logic       ack_q, ack_d;
  logic       halted_q, halted_d;
  logic       halt_q, halt_d;
  logic       rst_done;

  reset_stretch #(.RESET_HOLD(RESET_HOLD)) u_reset_stretch (
    .clk_i       (PCLK),
    .rst_ni      (PRESETn),
    .req_i       (RESET_REQUEST),
    .done_o      (rst_done),
    .core_rst_no (CPU_RESETn)
  );

`ifndef SINGLE_STEP_EN
  logic unused_step_inputs;
  assign unused_step_inputs = STEP_REQUEST ^ CPU_RETIRE;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_RESETTING: if (rst_done) state_d = DEBUG_REQUEST ? S_HALTING : S_RUN;
      S_RUN:       if (DEBUG_REQUEST) state_d = S_HALTING;
      S_HALTING: begin
        if (CPU_IDLE)                       state_d = S_HALTED;
        else if (!DEBUG_REQUEST && !pend_q) state_d = S_RUN;
      end
      S_HALTED: begin
        // Resume takes priority over a same-cycle step request.
        if (!DEBUG_REQUEST) state_d = S_RUN;
`ifdef SINGLE_STEP_EN
        else if (STEP_REQUEST) state_d = S_STEPPING;
`endif
      end
`ifdef SINGLE_STEP_EN
      S_STEPPING:  if (CPU_RETIRE) state_d = S_HALTING;
`endif
      default:     state_d = S_RESETTING;
    endcase
    if (RESET_REQUEST) state_d = S_RESETTING;

`ifdef SINGLE_STEP_EN
    if (state_d == S_STEPPING) pend_d = 1'b1;
    if (state_d == S_HALTED || state_d == S_RESETTING) pend_d = 1'b0;
`else
    pend_d = 1'b0;
`endif

    // Outputs are registered from the state being entered.
    halt_d   = 1'b0;
    halted_d = 1'b0;
    ack_d    = 1'b0;
    unique case (state_d)
      S_RESETTING: halt_d = DEBUG_REQUEST;
      S_HALTING: begin
        halt_d = 1'b1;
        ack_d  = pend_d;
      end
      S_HALTED: begin
        halt_d   = 1'b1;
        halted_d = 1'b1;
        ack_d    = 1'b1;
      end
      S_STEPPING:  ack_d = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_RESETTING;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      halted_q <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      halted_q <= halted_d;
      halt_q   <= halt_d;
    end
  end

  assign DEBUG_ACK = ack_q;
  assign HALTED    = halted_q;
  assign CPU_HALT  = halt_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Bench for debug_ctrl: directed protocol scenarios with literal expectations,
// then random traffic, all cross-checked each cycle against a behavioural model.
module tb_debug_ctrl;

  localparam int HOLD = 4;
`ifdef SINGLE_STEP_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif

  logic PCLK, PRESETn;
  logic DEBUG_REQUEST, RESET_REQUEST, STEP_REQUEST, CPU_IDLE, CPU_RETIRE;
  logic DEBUG_ACK, HALTED, CPU_HALT, CPU_RESETn;

  int checks = 0;
  int passes = 0;

  debug_ctrl #(.RESET_HOLD(HOLD)) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .DEBUG_REQUEST (DEBUG_REQUEST),
    .RESET_REQUEST (RESET_REQUEST),
    .STEP_REQUEST  (STEP_REQUEST),
    .DEBUG_ACK     (DEBUG_ACK),
    .HALTED        (HALTED),
    .CPU_HALT      (CPU_HALT),
    .CPU_IDLE      (CPU_IDLE),
    .CPU_RETIRE    (CPU_RETIRE),
    .CPU_RESETn    (CPU_RESETn)
  );

  // ---------------- clock ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------- behavioural model ----------------
  // Mode of the core as seen from outside; reset length counted as quiet edges
  // since the last sampled RESET_REQUEST.
  typedef enum int {M_RST, M_RUN, M_HALTING, M_HALTED, M_STEP} mode_e;
  mode_e mode;
  int    quiet;
  bit    pend;
  bit    dr_s;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mode = M_RST; quiet = 0; pend = 0; dr_s = 0;
    end else begin
      dr_s = DEBUG_REQUEST;
      if (RESET_REQUEST) begin
        mode = M_RST; quiet = 0; pend = 0;
      end else begin
        case (mode)
          M_RST: begin
            quiet++;
            if (quiet > HOLD) mode = DEBUG_REQUEST ? M_HALTING : M_RUN;
          end
          M_RUN: if (DEBUG_REQUEST) mode = M_HALTING;
          M_HALTING: begin
            if (CPU_IDLE) begin mode = M_HALTED; pend = 0; end
            else if (!DEBUG_REQUEST && !pend) mode = M_RUN;
          end
          M_HALTED: begin
            if (!DEBUG_REQUEST) mode = M_RUN;
            else if (STEP_ON && STEP_REQUEST) begin mode = M_STEP; pend = 1; end
          end
          M_STEP: if (CPU_RETIRE) mode = M_HALTING;
          default: mode = M_RST;
        endcase
      end
    end
  end

  // {CPU_RESETn, CPU_HALT, HALTED, DEBUG_ACK}
  function automatic logic [3:0] model_out();
    logic rn, h, hd, a;
    rn = (mode != M_RST);
    h  = (mode == M_RST) ? dr_s : (mode == M_HALTING || mode == M_HALTED);
    hd = (mode == M_HALTED);
    a  = (mode == M_HALTED) || pend;
    return {rn, h, hd, a};
  endfunction

  function automatic logic [3:0] dut_out();
    return {CPU_RESETn, CPU_HALT, HALTED, DEBUG_ACK};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got {rstn,halt,halted,ack}=%b expected %b at %0t", name, got, exp, $time);
  endtask

  always @(negedge PCLK) check("model", dut_out(), model_out());

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic expect_after(input string name, input logic [3:0] exp);
    cyc();
    check(name, dut_out(), exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic ack_seen;
    PRESETn = 1'b0; DEBUG_REQUEST = 0; RESET_REQUEST = 0; STEP_REQUEST = 0;
    CPU_IDLE = 0; CPU_RETIRE = 0;
    cyc(3);
    check("reset_state", dut_out(), 4'b0000);
    PRESETn = 1'b1;

    // Power-up stretch: release on the 5th edge after PRESETn deasserts.
    cyc(4);
    check("powerup_edge4", dut_out(), 4'b0000);
    expect_after("powerup_edge5", 4'b1000);
    expect_after("run_steady", 4'b1000);

    // Halt then resume.
    DEBUG_REQUEST = 1;
    expect_after("halt_req", 4'b1100);
    cyc(2);
    CPU_IDLE = 1;
    expect_after("halted", 4'b1111);
    CPU_IDLE = 0; DEBUG_REQUEST = 0;
    expect_after("resume", 4'b1000);

    // Abort before the core goes idle.
    ack_seen = 0;
    DEBUG_REQUEST = 1;
    cyc(); ack_seen |= DEBUG_ACK;
    cyc(); ack_seen |= DEBUG_ACK;
    DEBUG_REQUEST = 0;
    expect_after("abort", 4'b1000);
    check("abort_no_ack", {3'b000, ack_seen}, 4'b0000);

    // Reset while halted; core comes back up stalled.
    DEBUG_REQUEST = 1;
    cyc();
    CPU_IDLE = 1;
    expect_after("halted2", 4'b1111);
    CPU_IDLE = 0; RESET_REQUEST = 1;
    expect_after("rst_in_halt", 4'b0100);
    cyc(2);
    RESET_REQUEST = 0;
    cyc(4);
    check("rst_hold_edge4", dut_out(), 4'b0100);
    expect_after("rst_release_stalled", 4'b1100);
    CPU_IDLE = 1;
    expect_after("halted3", 4'b1111);
    CPU_IDLE = 0;

`ifdef SINGLE_STEP_EN
    STEP_REQUEST = 1;
    expect_after("step_start", 4'b1001);
    STEP_REQUEST = 0;
    expect_after("step_wait", 4'b1001);
    CPU_RETIRE = 1;
    expect_after("step_retire", 4'b1101);
    CPU_RETIRE = 0; CPU_IDLE = 1;
    expect_after("step_halted", 4'b1111);
    CPU_IDLE = 0;
`else
    STEP_REQUEST = 1;
    expect_after("step_ignored", 4'b1111);
    STEP_REQUEST = 0;
`endif

    // Same-cycle resume and step: resume wins, later retire is ignored.
    DEBUG_REQUEST = 0; STEP_REQUEST = 1;
    expect_after("simul_resume", 4'b1000);
    STEP_REQUEST = 0; CPU_RETIRE = 1;
    expect_after("retire_ignored", 4'b1000);
    CPU_RETIRE = 0;

    // Asynchronous reset mid-halt, between clock edges.
    DEBUG_REQUEST = 1;
    cyc();
    #3 PRESETn = 1'b0;
    #1 check("async_reset", dut_out(), 4'b0000);
    cyc();
    PRESETn = 1'b1; DEBUG_REQUEST = 0;
    cyc(7);
    check("after_async", dut_out(), 4'b1000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) DEBUG_REQUEST = ~DEBUG_REQUEST;
      RESET_REQUEST = ($urandom_range(0, 79) == 0);
      STEP_REQUEST  = ($urandom_range(0, 7) == 0);
      CPU_IDLE      = ($urandom_range(0, 3) == 0);
      CPU_RETIRE    = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
